// File: rtl/shift_issue_stage.sv
// ID/EX register for the barrel shifter: decodes SPECIAL shifts, forwards EX/MEM and MEM/WB results.
// Latency: 1 cycle ID->EX; Shift_in and variable Shift_amount pass through one forwarding mux after the register.
// Backpressure: stall holds control and refreshes the operands from the forwarding mux; flush (wins over stall) inserts a bubble.
// Optional feature macro: SHIFT_ROTR_EN enables ROTR/ROTRV decode (Shift_op = 2'b11).
module shift_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_wr,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_wr,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic        ex_valid,
  output logic        ex_is_shift,
  output logic        ex_wr,
  output logic [4:0]  ex_rd,
  output logic [31:0] Shift_in,
  output logic [4:0]  Shift_amount,
  output logic [1:0]  Shift_op
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  // ID/EX state
  logic        r_valid;
  logic        r_is_shift;
  logic [1:0]  r_op;
  logic [4:0]  r_amt;      // immediate shamt; zero for variable forms
  logic        r_var;      // amount comes from forwarded rs
  logic [4:0]  r_rd;
  logic [4:0]  r_rs_num;
  logic [4:0]  r_rt_num;
  logic [31:0] r_rs_dat;
  logic [31:0] r_rt_dat;

  // Decode results
  logic        w_dec_shift;
  logic [1:0]  w_dec_op;
  logic [4:0]  w_dec_amt;
  logic        w_dec_var;

  // Forwarded operands
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  // Decode SPECIAL-opcode shifts into shifter controls; anything else is a non-shift.
  always_comb begin
    w_dec_shift = 1'b0;
    w_dec_op    = OP_SLL;
    w_dec_amt   = 5'd0;
    w_dec_var   = 1'b0;
    if (id_instr[31:26] == 6'b000000) begin
      unique case (id_instr[5:0])
        6'b000000: begin
          w_dec_shift = 1'b1;
          w_dec_op    = OP_SLL;
          w_dec_amt   = id_instr[10:6];
        end
        6'b000010: begin
          w_dec_shift = 1'b1;
          w_dec_op    = OP_SRL;
          w_dec_amt   = id_instr[10:6];
`ifdef SHIFT_ROTR_EN
          if (id_instr[21]) w_dec_op = OP_ROTR;
`endif
        end
        6'b000011: begin
          w_dec_shift = 1'b1;
          w_dec_op    = OP_SRA;
          w_dec_amt   = id_instr[10:6];
        end
        6'b000100: begin
          w_dec_shift = 1'b1;
          w_dec_op    = OP_SLL;
          w_dec_var   = 1'b1;
        end
        6'b000110: begin
          w_dec_shift = 1'b1;
          w_dec_op    = OP_SRL;
          w_dec_var   = 1'b1;
`ifdef SHIFT_ROTR_EN
          if (id_instr[6]) w_dec_op = OP_ROTR;
`endif
        end
        6'b000111: begin
          w_dec_shift = 1'b1;
          w_dec_op    = OP_SRA;
          w_dec_var   = 1'b1;
        end
        default: begin
          w_dec_shift = 1'b0;
          w_dec_op    = OP_SLL;
        end
      endcase
    end
  end

  // Forward per operand: nearest producer (EX/MEM) first, then MEM/WB, never from $0.
  always_comb begin
    w_fwd_rs = r_rs_dat;
    if (exmem_wr && (exmem_rd != 5'd0) && (exmem_rd == r_rs_num))
      w_fwd_rs = exmem_result;
    else if (memwb_wr && (memwb_rd != 5'd0) && (memwb_rd == r_rs_num))
      w_fwd_rs = memwb_result;

    w_fwd_rt = r_rt_dat;
    if (exmem_wr && (exmem_rd != 5'd0) && (exmem_rd == r_rt_num))
      w_fwd_rt = exmem_result;
    else if (memwb_wr && (memwb_rd != 5'd0) && (memwb_rd == r_rt_num))
      w_fwd_rt = memwb_result;
  end

  // ID/EX register: flush beats stall; a stall refreshes operands so retiring forwards are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_is_shift <= 1'b0;
      r_op       <= OP_SLL;
      r_amt      <= 5'd0;
      r_var      <= 1'b0;
      r_rd       <= 5'd0;
      r_rs_num   <= 5'd0;
      r_rt_num   <= 5'd0;
      r_rs_dat   <= 32'd0;
      r_rt_dat   <= 32'd0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_is_shift <= 1'b0;
      r_op       <= OP_SLL;
      r_amt      <= 5'd0;
      r_var      <= 1'b0;
    end else if (stall) begin
      r_rs_dat   <= w_fwd_rs;
      r_rt_dat   <= w_fwd_rt;
    end else begin
      // An empty ID slot enters EX as a clean bubble regardless of the instruction bits.
      r_valid    <= id_valid;
      r_is_shift <= id_valid & w_dec_shift;
      r_op       <= id_valid ? w_dec_op : OP_SLL;
      r_amt      <= id_valid ? w_dec_amt : 5'd0;
      r_var      <= id_valid & w_dec_var;
      r_rd       <= id_instr[15:11];
      r_rs_num   <= id_instr[25:21];
      r_rt_num   <= id_instr[20:16];
      r_rs_dat   <= id_rs_data;
      r_rt_dat   <= id_rt_data;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_is_shift  = r_is_shift;
  assign ex_rd        = r_rd;
  assign ex_wr        = r_valid & r_is_shift & (r_rd != 5'd0);
  assign Shift_op     = r_op;
  assign Shift_in     = w_fwd_rt;
  assign Shift_amount = r_var ? w_fwd_rs[4:0] : r_amt;

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
  logic        exmem_wr;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_wr;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        ex_valid;
  logic        ex_is_shift;
  logic        ex_wr;
  logic [4:0]  ex_rd;
  logic [31:0] Shift_in;
  logic [4:0]  Shift_amount;
  logic [1:0]  Shift_op;

`ifdef SHIFT_ROTR_EN
  localparam logic [1:0] ROP = 2'b11;
`else
  localparam logic [1:0] ROP = 2'b01;
`endif

  shift_issue_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .stall        (stall),
    .flush        (flush),
    .exmem_wr     (exmem_wr),
    .exmem_rd     (exmem_rd),
    .exmem_result (exmem_result),
    .memwb_wr     (memwb_wr),
    .memwb_rd     (memwb_rd),
    .memwb_result (memwb_result),
    .ex_valid     (ex_valid),
    .ex_is_shift  (ex_is_shift),
    .ex_wr        (ex_wr),
    .ex_rd        (ex_rd),
    .Shift_in     (Shift_in),
    .Shift_amount (Shift_amount),
    .Shift_op     (Shift_op)
  );

  typedef struct {
    logic [8*8-1:0] name;
    logic           valid;
    logic           is_shift;
    logic           wr;
    logic [4:0]     rd;
    logic [31:0]    sin;
    logic [4:0]     amt;
    logic [1:0]     op;
    bit             chk_rd;
    bit             chk_in;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt);
    id_valid   = v;
    id_instr   = ins;
    id_rs_data = rs;
    id_rt_data = rt;
  endtask

  task automatic set_fwd(input logic aw, input logic [4:0] ard, input logic [31:0] ares,
                         input logic bw, input logic [4:0] brd, input logic [31:0] bres);
    exmem_wr     = aw;
    exmem_rd     = ard;
    exmem_result = ares;
    memwb_wr     = bw;
    memwb_rd     = brd;
    memwb_result = bres;
  endtask

  task automatic expect_out(input logic [8*8-1:0] nm, input logic v, input logic s,
                            input logic w, input logic [4:0] rd, input logic [31:0] sin,
                            input logic [4:0] amt, input logic [1:0] op,
                            input bit crd, input bit cin);
    exp_t e;
    e.name = nm; e.valid = v; e.is_shift = s; e.wr = w; e.rd = rd;
    e.sin = sin; e.amt = amt; e.op = op; e.chk_rd = crd; e.chk_in = cin;
    sb.push_back(e);
  endtask

  // Monitor: every negedge, compare all expectations queued for the current EX contents.
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        bad = (ex_valid !== e.valid) || (ex_is_shift !== e.is_shift) || (ex_wr !== e.wr) ||
              (Shift_amount !== e.amt) || (Shift_op !== e.op) ||
              (e.chk_rd && (ex_rd !== e.rd)) || (e.chk_in && (Shift_in !== e.sin));
        n_tests++;
        if (bad) begin
          n_fail++;
          $display("FAIL %0s: got v=%b s=%b w=%b rd=%0d in=%h amt=%0d op=%b ; want v=%b s=%b w=%b rd=%0d in=%h amt=%0d op=%b",
                   e.name, ex_valid, ex_is_shift, ex_wr, ex_rd, Shift_in, Shift_amount, Shift_op,
                   e.valid, e.is_shift, e.wr, e.rd, e.sin, e.amt, e.op);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    set_id(1'b0, 32'd0, 32'd0, 32'd0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Reset held, then released with an empty ID slot.
    tick();
    expect_out("rst_hold", 0, 0, 0, 5'd0, 32'd0, 5'd0, 2'b00, 1, 1);
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("rst_rel", 0, 0, 0, 5'd0, 32'd0, 5'd0, 2'b00, 1, 1);

    // SRA $3,$2,4
    set_id(1'b1, rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'b000011), 32'd0, 32'h8000_0010);
    tick();
    expect_out("sra", 1, 1, 1, 5'd3, 32'h8000_0010, 5'd4, 2'b10, 1, 1);
    set_id(1'b1, rtype(5'd0, 5'd9, 5'd8, 5'd2, 6'b000010), 32'd0, 32'h1111_1111);

    // Async reset mid-cycle clears outputs before any further clock edge.
    tick();
    set_id(1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    rst_n = 1'b0;
    expect_out("arst", 0, 0, 0, 5'd0, 32'd0, 5'd0, 2'b00, 1, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // SLLV $5,$6,$7 with both forwarding sources writing $7.
    set_id(1'b1, rtype(5'd7, 5'd6, 5'd5, 5'd0, 6'b000100), 32'h0000_001F, 32'h1234_5678);
    tick();
    stall = 1'b1;
    set_fwd(1'b1, 5'd7, 32'h0000_0023, 1'b1, 5'd7, 32'h0000_0001);
    expect_out("sllv_a", 1, 1, 1, 5'd5, 32'h1234_5678, 5'd3, 2'b00, 1, 1);
    tick();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0001);
    expect_out("sllv_b", 1, 1, 1, 5'd5, 32'h1234_5678, 5'd1, 2'b00, 1, 1);
    tick();
    // rs was refreshed to 0x01 during the stall; no forward now.
    stall = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_out("sllv_c", 1, 1, 1, 5'd5, 32'h1234_5678, 5'd1, 2'b00, 1, 1);

    // SRL $8,$9,2; 3-cycle stall, MEM/WB supplies rt only in the first stall cycle.
    set_id(1'b1, rtype(5'd0, 5'd9, 5'd8, 5'd2, 6'b000010), 32'd0, 32'h1111_1111);
    tick();
    stall = 1'b1;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hDEAD_BEEF);
    set_id(1'b1, rtype(5'd3, 5'd4, 5'd5, 5'd6, 6'b000011), 32'h5555_5555, 32'h5555_5555);
    expect_out("stl0", 1, 1, 1, 5'd8, 32'hDEAD_BEEF, 5'd2, 2'b01, 1, 1);
    tick();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_out("stl1", 1, 1, 1, 5'd8, 32'hDEAD_BEEF, 5'd2, 2'b01, 1, 1);
    tick();
    expect_out("stl2", 1, 1, 1, 5'd8, 32'hDEAD_BEEF, 5'd2, 2'b01, 1, 1);
    tick();
    stall = 1'b0;
    set_id(1'b0, 32'd0, 32'd0, 32'd0);
    expect_out("stl_rel", 1, 1, 1, 5'd8, 32'hDEAD_BEEF, 5'd2, 2'b01, 1, 1);
    tick();
    expect_out("idle", 0, 0, 0, 5'd0, 32'd0, 5'd0, 2'b00, 1, 1);

    // SRAV $10,$2,$3 with rs=0x3F -> amount 31.
    set_id(1'b1, rtype(5'd3, 5'd2, 5'd10, 5'd0, 6'b000111), 32'h0000_003F, 32'h0000_00F0);
    tick();
    expect_out("srav", 1, 1, 1, 5'd10, 32'h0000_00F0, 5'd31, 2'b10, 1, 1);
    // Stall and flush together: flush wins.
    stall = 1'b1;
    flush = 1'b1;
    set_id(1'b1, rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'b000011), 32'd0, 32'h8000_0010);
    tick();
    stall = 1'b0;
    flush = 1'b0;
    expect_out("flush", 0, 0, 0, 5'd0, 32'd0, 5'd0, 2'b00, 0, 0);

    // NOP decodes as SLL $0 -> shift but no write.
    set_id(1'b1, 32'h0000_0000, 32'd0, 32'd0);
    tick();
    expect_out("nop", 1, 1, 0, 5'd0, 32'd0, 5'd0, 2'b00, 1, 1);

    // ROTR $1,$2,8 (bit 21 set).
    set_id(1'b1, rtype(5'd1, 5'd2, 5'd1, 5'd8, 6'b000010), 32'd0, 32'h0000_ABCD);
    tick();
    expect_out("rotr", 1, 1, 1, 5'd1, 32'h0000_ABCD, 5'd8, ROP, 1, 1);

    // ROTRV $4,$2,$3 (bit 6 set), rs=0x27 -> amount 7.
    set_id(1'b1, rtype(5'd3, 5'd2, 5'd4, 5'd1, 6'b000110), 32'h0000_0027, 32'h0000_0001);
    tick();
    expect_out("rotrv", 1, 1, 1, 5'd4, 32'h0000_0001, 5'd7, ROP, 1, 1);

    // Funct 000001 is not a shift.
    set_id(1'b1, rtype(5'd0, 5'd2, 5'd6, 5'd0, 6'b000001), 32'd0, 32'h0000_0077);
    tick();
    expect_out("funct1", 1, 0, 0, 5'd6, 32'h0000_0077, 5'd0, 2'b00, 1, 1);

    // Non-zero opcode with funct bits of SLL is not a shift.
    set_id(1'b1, {6'b001000, 5'd0, 5'd2, 5'd9, 5'd3, 6'b000000}, 32'd0, 32'h0000_0005);
    tick();
    expect_out("opcode", 1, 0, 0, 5'd9, 32'h0000_0005, 5'd0, 2'b00, 1, 1);

    // SLL $2,$0,1: writers to $0 must never forward.
    set_id(1'b1, rtype(5'd0, 5'd0, 5'd2, 5'd1, 6'b000000), 32'd0, 32'd0);
    tick();
    set_fwd(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
    expect_out("rd0", 1, 1, 1, 5'd2, 32'd0, 5'd1, 2'b00, 1, 1);

    // SLL $4,$9,1: EX/MEM writes another reg, MEM/WB writes $9 -> MEM/WB used.
    set_id(1'b1, rtype(5'd0, 5'd9, 5'd4, 5'd1, 6'b000000), 32'd0, 32'h0000_0010);
    tick();
    set_fwd(1'b1, 5'd5, 32'h0000_AAAA, 1'b1, 5'd9, 32'h0000_0BAD);
    set_id(1'b0, 32'd0, 32'd0, 32'd0);
    expect_out("mwb_rt", 1, 1, 1, 5'd4, 32'h0000_0BAD, 5'd1, 2'b00, 1, 1);
    tick();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_out("idle2", 0, 0, 0, 5'd0, 32'd0, 5'd0, 2'b00, 1, 1);

    // Reset during a stall discards the held instruction.
    set_id(1'b1, rtype(5'd0, 5'd8, 5'd7, 5'd5, 6'b000000), 32'd0, 32'h0000_0099);
    tick();
    stall = 1'b1;
    set_id(1'b0, 32'd0, 32'd0, 32'd0);
    expect_out("sll7", 1, 1, 1, 5'd7, 32'h0000_0099, 5'd5, 2'b00, 1, 1);
    tick();
    #1;
    rst_n = 1'b0;
    expect_out("rst_stl", 0, 0, 0, 5'd0, 32'd0, 5'd0, 2'b00, 1, 1);
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("post_rst", 0, 0, 0, 5'd0, 32'd0, 5'd0, 2'b00, 1, 1);
    stall = 1'b0;
    tick();

    // Let the monitor drain; anything left unchecked is itself a failure.
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
